// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit segment scanner.
// The optional dimming feature is enabled by defining SEG_SCAN_DIM_EN.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } scan_state_e;

    localparam logic [1:0] DIG_NONE  = 2'b00;
    localparam logic [1:0] DIG0      = 2'b01;
    localparam logic [1:0] DIG1      = 2'b10;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg_scan_mux_scan_timer.sv
// Slot counter for the segment scanner: counts 0..DIV_CYCLES-1 and flags
// the last blank cycle and the last cycle of the slot.
module scan_timer #(
    parameter int DIV_CYCLES   = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int CW          = $clog2(DIV_CYCLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          blank_done,
    output logic          slot_end
);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV_CYCLES - 1);

    assign blank_done = (cnt == BLANK_LAST);
    assign slot_end   = (cnt == SLOT_LAST);

    // cnt_nxt is exported so the owner can register outputs for the coming cycle.
    always_comb begin
        cnt_nxt = '0;
        if (en && !slot_end) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit time-multiplexed seven-segment driver with blanking gaps and a
// per-frame input snapshot. Define SEG_SCAN_DIM_EN to add the dim input.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIV_CYCLES   = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
`ifdef SEG_SCAN_DIM_EN
    input  logic       dim,
`endif
    input  logic [7:0] SevenSegDig1,
    input  logic [7:0] SevenSegDig2,
    output logic [7:0] seg_out,
    output logic [1:0] dig_en,
    output logic       frame_tick
);

    localparam int CW = $clog2(DIV_CYCLES);

    scan_state_e   state;
    scan_state_e   state_nxt;
    logic          active;
    logic          run;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          blank_done;
    logic          slot_end;
    logic [7:0]    snap0;
    logic [7:0]    snap1;
    logic [7:0]    snap0_nxt;
    logic [7:0]    snap1_nxt;
    logic [7:0]    seg_nxt;
    logic [1:0]    dig_nxt;
    logic          tick_nxt;
    logic          show_ok;

    // active marks that the previous cycle was enabled; the first enabled
    // cycle after reset or en=0 is held at frame start as the capture cycle.
    assign run = en & active;

    scan_timer #(
        .DIV_CYCLES  (DIV_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (run),
        .cnt       (cnt),
        .cnt_nxt   (cnt_nxt),
        .blank_done(blank_done),
        .slot_end  (slot_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BLANK0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= en;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = BLANK0;
        end else begin
            case (state)
                BLANK0:  if (blank_done) state_nxt = SHOW0;
                SHOW0:   if (slot_end)   state_nxt = BLANK1;
                BLANK1:  if (blank_done) state_nxt = SHOW1;
                SHOW1:   if (slot_end)   state_nxt = BLANK0;
                default: state_nxt = BLANK0;
            endcase
        end
    end

    // frame_tick is high exactly in the capture cycle, so it doubles as the load enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap0 <= SEG_BLANK;
            snap1 <= SEG_BLANK;
        end else if (frame_tick) begin
            snap0 <= SevenSegDig1;
            snap1 <= SevenSegDig2;
        end
    end

    // Forward the snapshot being loaded so a one-cycle blank still shows fresh data.
    assign snap0_nxt = frame_tick ? SevenSegDig1 : snap0;
    assign snap1_nxt = frame_tick ? SevenSegDig2 : snap1;

`ifdef SEG_SCAN_DIM_EN
    localparam logic [CW-1:0] DIM_END = CW'(BLANK_CYCLES + (DIV_CYCLES - BLANK_CYCLES) / 2);
    assign show_ok = !dim || (cnt_nxt < DIM_END);
`else
    assign show_ok = 1'b1;
`endif

    always_comb begin
        seg_nxt  = SEG_BLANK;
        dig_nxt  = DIG_NONE;
        tick_nxt = en && (!active || (state_nxt == BLANK0 && cnt_nxt == '0));
        case (state_nxt)
            SHOW0: begin
                if (show_ok) begin
                    seg_nxt = snap0_nxt;
                    dig_nxt = DIG0;
                end
            end
            SHOW1: begin
                if (show_ok) begin
                    seg_nxt = snap1_nxt;
                    dig_nxt = DIG1;
                end
            end
            default: begin
                seg_nxt = SEG_BLANK;
                dig_nxt = DIG_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= SEG_BLANK;
            dig_en     <= DIG_NONE;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_nxt;
            dig_en     <= dig_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux at DIV_CYCLES=8, BLANK_CYCLES=2 (16-cycle frame).
// Define SEG_SCAN_DIM_EN to also exercise the dim input.
module tb_seg_scan_mux;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dim;
    logic [7:0] dig1;
    logic [7:0] dig2;
    logic [7:0] seg_out;
    logic [1:0] dig_en;
    logic       frame_tick;

    int         n_cmp;
    int         n_err;
    int         pos;
    logic [7:0] m0;
    logic [7:0] m1;

    seg_scan_mux #(
        .DIV_CYCLES  (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
`ifdef SEG_SCAN_DIM_EN
        .dim         (dim),
`endif
        .SevenSegDig1(dig1),
        .SevenSegDig2(dig2),
        .seg_out     (seg_out),
        .dig_en      (dig_en),
        .frame_tick  (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (frame pos %0d, t=%0t)", tag, obs, exp, pos, $time);
        end
    endtask

    // Expected {frame_tick, dig_en, seg_out} at a given position in the frame.
    function automatic logic [10:0] expect_at(input int p, input logic dm);
        logic       t;
        logic [1:0] d;
        logic [7:0] s;
        t = (p == 0);
        d = 2'b00;
        s = 8'h00;
        if (p >= 2 && p <= 7 && (!dm || p <= 4)) begin
            d = 2'b01;
            s = m0;
        end else if (p >= 10 && p <= 15 && (!dm || p <= 12)) begin
            d = 2'b10;
            s = m1;
        end
        return {t, d, s};
    endfunction

    task automatic step_check();
        logic dm;
        @(posedge clk);
        @(negedge clk);
        // Inputs seen here were stable across the capture edge ending pos 0.
        if (pos == 1) begin
            m0 = dig1;
            m1 = dig2;
        end
`ifdef SEG_SCAN_DIM_EN
        dm = dim;
`else
        dm = 1'b0;
`endif
        check_eq("scan", {5'b0, frame_tick, dig_en, seg_out}, {5'b0, expect_at(pos, dm)});
        check_eq("dig_onehot", {15'b0, dig_en == 2'b11}, 16'h0000);
        pos = (pos + 1) % 16;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        pos   = 0;
        m0    = 8'h00;
        m1    = 8'h00;
        rst_n = 1'b0;
        en    = 1'b0;
        dim   = 1'b0;
        dig1  = 8'h3F;
        dig2  = 8'h06;

        repeat (3) @(negedge clk);
        check_eq("rst_seg", {8'b0, seg_out}, 16'h0000);
        check_eq("rst_dig", {14'b0, dig_en}, 16'h0000);
        check_eq("rst_tick", {15'b0, frame_tick}, 16'h0000);

        // Two frames; Dig1 changes mid-SHOW0 of the first frame.
        en    = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 28; i++) begin
            step_check();
            if (i == 4) dig1 = 8'h5B;
        end

        // en dropped during SHOW1: blank and idle from the next edge.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("idle_out", {5'b0, frame_tick, dig_en, seg_out}, 16'h0000);
        end
        en  = 1'b1;
        pos = 0;
        for (int i = 0; i < 16; i++) step_check();

        // Asynchronous reset in the middle of SHOW0.
        for (int i = 0; i < 5; i++) step_check();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_seg", {8'b0, seg_out}, 16'h0000);
        check_eq("async_dig", {14'b0, dig_en}, 16'h0000);
        dig1 = 8'h77;
        dig2 = 8'h39;
        @(negedge clk);
        rst_n = 1'b1;
        pos   = 0;
        for (int i = 0; i < 16; i++) step_check();

        // Four frames with dp set on digit 0 and digit 1 dark.
        dig1 = 8'hFF;
        dig2 = 8'h00;
        for (int i = 0; i < 64; i++) begin
            step_check();
            if (i == 2) check_eq("dp_bit", {15'b0, seg_out[7]}, 16'h0001);
        end

`ifdef SEG_SCAN_DIM_EN
        dim  = 1'b1;
        dig1 = 8'h3F;
        dig2 = 8'h06;
        for (int i = 0; i < 32; i++) step_check();
        dim = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
